// File: rtl/picomem_psram_arbiter.sv
// ============================================================================
// Module  : picomem_psram_arbiter
// Purpose : Two-port valid/ready arbiter sharing one PicoMem PSRAM controller.
//           Optional per-port grant counters when ARB_STATS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module picomem_psram_arbiter #(
    parameter int ADDR_W = 23,
    parameter int RR     = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              sys_reset,
    input  logic              init_ready,
    input  logic              s0_valid,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [3:0]        s0_wstrb,
    input  logic [31:0]       s0_wdata,
    output logic [31:0]       s0_rdata,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [3:0]        s1_wstrb,
    input  logic [31:0]       s1_wdata,
    output logic [31:0]       s1_rdata,
    output logic              s1_ready,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_wstrb,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    input  logic              m_ready,
    output logic              grant,
    output logic              busy,
    output logic [CNT_W-1:0]  s0_grants,
    output logic [CNT_W-1:0]  s1_grants
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                m_valid_q, m_valid_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [3:0]          m_wstrb_q, m_wstrb_d;
    logic [31:0]         m_wdata_q, m_wdata_d;
    logic                grant_q, grant_d;
    logic [31:0]         s0_rdata_q, s0_rdata_d;
    logic [31:0]         s1_rdata_q, s1_rdata_d;
    logic                s0_ready_q, s0_ready_d;
    logic                s1_ready_q, s1_ready_d;
    logic                w_pick;

    // Port 1 wins when alone, or under round-robin when port 0 was served last.
    assign w_pick = s1_valid && (!s0_valid || ((RR != 0) && !grant_q));

    always_comb begin
        state_d    = state_q;
        m_valid_d  = m_valid_q;
        m_addr_d   = m_addr_q;
        m_wstrb_d  = m_wstrb_q;
        m_wdata_d  = m_wdata_q;
        grant_d    = grant_q;
        s0_rdata_d = s0_rdata_q;
        s1_rdata_d = s1_rdata_q;
        s0_ready_d = 1'b0;
        s1_ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_ready && (s0_valid || s1_valid)) begin
                    grant_d   = w_pick;
                    m_valid_d = 1'b1;
                    m_addr_d  = w_pick ? s1_addr  : s0_addr;
                    m_wstrb_d = w_pick ? s1_wstrb : s0_wstrb;
                    m_wdata_d = w_pick ? s1_wdata : s0_wdata;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (grant_q) begin
                        s1_rdata_d = m_rdata;
                        s1_ready_d = 1'b1;
                    end else begin
                        s0_rdata_d = m_rdata;
                        s0_ready_d = 1'b1;
                    end
                    state_d = RELEASE;
                end
            end
            // Dead cycle: guarantees the controller sees valid low between requests.
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q    <= IDLE;
            m_valid_q  <= 1'b0;
            m_addr_q   <= '0;
            m_wstrb_q  <= 4'd0;
            m_wdata_q  <= 32'd0;
            grant_q    <= 1'b1;
            s0_rdata_q <= 32'd0;
            s1_rdata_q <= 32'd0;
            s0_ready_q <= 1'b0;
            s1_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_valid_q  <= m_valid_d;
            m_addr_q   <= m_addr_d;
            m_wstrb_q  <= m_wstrb_d;
            m_wdata_q  <= m_wdata_d;
            grant_q    <= grant_d;
            s0_rdata_q <= s0_rdata_d;
            s1_rdata_q <= s1_rdata_d;
            s0_ready_q <= s0_ready_d;
            s1_ready_q <= s1_ready_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_addr   = m_addr_q;
    assign m_wstrb  = m_wstrb_q;
    assign m_wdata  = m_wdata_q;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);
    assign s0_rdata = s0_rdata_q;
    assign s1_rdata = s1_rdata_q;
    assign s0_ready = s0_ready_q;
    assign s1_ready = s1_ready_q;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] s0_grants_q, s0_grants_d;
    logic [CNT_W-1:0] s1_grants_q, s1_grants_d;

    // Counters saturate rather than wrap.
    always_comb begin
        s0_grants_d = s0_grants_q;
        s1_grants_d = s1_grants_q;
        if (s0_ready_d && (s0_grants_q != '1)) s0_grants_d = s0_grants_q + CNT_W'(1);
        if (s1_ready_d && (s1_grants_q != '1)) s1_grants_d = s1_grants_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            s0_grants_q <= '0;
            s1_grants_q <= '0;
        end else begin
            s0_grants_q <= s0_grants_d;
            s1_grants_q <= s1_grants_d;
        end
    end

    assign s0_grants = s0_grants_q;
    assign s1_grants = s1_grants_q;
`else
    assign s0_grants = '0;
    assign s1_grants = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_picomem_psram_arbiter.sv
// ============================================================================
// Module  : tb_picomem_psram_arbiter
// Purpose : Self-checking bench; round-robin and fixed-priority instances share
//           requester stimulus, each with its own controller model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_picomem_psram_arbiter;

    logic        clk = 1'b0;
    logic        sys_reset = 1'b1;
    logic        init_ready = 1'b0;
    logic        s0_valid = 1'b0, s1_valid = 1'b0;
    logic [22:0] s0_addr = '0, s1_addr = '0;
    logic [3:0]  s0_wstrb = '0, s1_wstrb = '0;
    logic [31:0] s0_wdata = '0, s1_wdata = '0;
    logic [31:0] rd_val = '0;
    int          lat = 10;

    logic        rr_m_valid, rr_m_ready, rr_grant, rr_busy, rr_s0_ready, rr_s1_ready;
    logic [22:0] rr_m_addr;
    logic [3:0]  rr_m_wstrb;
    logic [31:0] rr_m_wdata, rr_s0_rdata, rr_s1_rdata;
    logic [15:0] rr_s0_grants, rr_s1_grants;
    logic        fp_m_valid, fp_m_ready, fp_grant, fp_busy, fp_s0_ready, fp_s1_ready;
    logic [22:0] fp_m_addr;
    logic [3:0]  fp_m_wstrb;
    logic [31:0] fp_m_wdata, fp_s0_rdata, fp_s1_rdata;
    logic [1:0]  fp_s0_grants, fp_s1_grants;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    picomem_psram_arbiter #(.ADDR_W(23), .RR(1), .CNT_W(16)) u_rr (
        .clk(clk), .sys_reset(sys_reset), .init_ready(init_ready),
        .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_wstrb(s0_wstrb), .s0_wdata(s0_wdata),
        .s0_rdata(rr_s0_rdata), .s0_ready(rr_s0_ready),
        .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_wstrb(s1_wstrb), .s1_wdata(s1_wdata),
        .s1_rdata(rr_s1_rdata), .s1_ready(rr_s1_ready),
        .m_valid(rr_m_valid), .m_addr(rr_m_addr), .m_wstrb(rr_m_wstrb), .m_wdata(rr_m_wdata),
        .m_rdata(rd_val), .m_ready(rr_m_ready),
        .grant(rr_grant), .busy(rr_busy), .s0_grants(rr_s0_grants), .s1_grants(rr_s1_grants)
    );

    picomem_psram_arbiter #(.ADDR_W(23), .RR(0), .CNT_W(2)) u_fp (
        .clk(clk), .sys_reset(sys_reset), .init_ready(init_ready),
        .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_wstrb(s0_wstrb), .s0_wdata(s0_wdata),
        .s0_rdata(fp_s0_rdata), .s0_ready(fp_s0_ready),
        .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_wstrb(s1_wstrb), .s1_wdata(s1_wdata),
        .s1_rdata(fp_s1_rdata), .s1_ready(fp_s1_ready),
        .m_valid(fp_m_valid), .m_addr(fp_m_addr), .m_wstrb(fp_m_wstrb), .m_wdata(fp_m_wdata),
        .m_rdata(rd_val), .m_ready(fp_m_ready),
        .grant(fp_grant), .busy(fp_busy), .s0_grants(fp_s0_grants), .s1_grants(fp_s1_grants)
    );

    // Controller models: one-cycle ready pulse after lat cycles of valid.
    int rr_cnt, fp_cnt;
    always @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            rr_cnt <= 0; rr_m_ready <= 1'b0;
        end else if (!rr_m_valid || rr_m_ready) begin
            rr_cnt <= 0; rr_m_ready <= 1'b0;
        end else if (rr_cnt == lat - 1) rr_m_ready <= 1'b1;
        else rr_cnt <= rr_cnt + 1;
    end
    always @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            fp_cnt <= 0; fp_m_ready <= 1'b0;
        end else if (!fp_m_valid || fp_m_ready) begin
            fp_cnt <= 0; fp_m_ready <= 1'b0;
        end else if (fp_cnt == lat - 1) fp_m_ready <= 1'b1;
        else fp_cnt <= fp_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rr_s0_ready || rr_s1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ready_timeout", {31'd0, ok}, 32'd1);
    endtask

    typedef struct {
        logic        v0, v1;
        logic [22:0] a0, a1;
        logic [3:0]  ws0, ws1;
        logic [31:0] wd0, wd1, rd;
        logic        g_rr, g_fp;
    } vec_t;

    vec_t vt[6];

    initial begin
        int viol;
        int n, r0, r1, f0, f1;
        bit done;

        vt[0] = '{1'b1, 1'b0, 23'h000004, 23'h0,      4'hF, 4'h0, 32'h1177C7C7, 32'h0,        32'h0,        1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 23'h0,      23'h7FFFFC, 4'h0, 4'h0, 32'h0,        32'h0,        32'hFFFF77C3, 1'b1, 1'b1};
        vt[2] = '{1'b1, 1'b1, 23'h000100, 23'h000200, 4'h3, 4'hC, 32'hAAAA5555, 32'h5555AAAA, 32'h12345678, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b1, 23'h000300, 23'h000400, 4'h0, 4'h1, 32'h01020304, 32'hDEADBEEF, 32'h87654321, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b1, 23'h7FFFFF, 23'h000001, 4'h8, 4'h0, 32'hCAFEF00D, 32'h0BADC0DE, 32'h00FF00FF, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 23'h0,      23'h7FFFFF, 4'h0, 4'hF, 32'h0,        32'hFEEDFACE, 32'hA5A5A5A5, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        sys_reset = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", {31'd0, rr_m_valid}, 32'd0);
        chk("rst_busy",    {31'd0, rr_busy}, 32'd0);
        chk("rst_grant",   {31'd0, rr_grant}, 32'd1);
        chk("rst_m_addr",  {9'd0, rr_m_addr}, 32'd0);
        chk("rst_rdata",   rr_s0_rdata | rr_s1_rdata, 32'd0);
        chk("rst_ready",   {30'd0, rr_s0_ready, rr_s1_ready}, 32'd0);
        chk("rst_grants",  {rr_s0_grants, rr_s1_grants}, 32'd0);

        // No grant while controller init is pending
        s0_valid = 1'b1; s0_addr = 23'h000010; s0_wstrb = 4'h0;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (rr_m_valid || fp_m_valid) viol++;
        end
        chk("init_block", viol, 0);
        init_ready = 1'b1;
        @(negedge clk);
        chk("init_m_valid_rr", {31'd0, rr_m_valid}, 32'd1);
        chk("init_m_valid_fp", {31'd0, fp_m_valid}, 32'd1);
        wait_ready();
        s0_valid = 1'b0;
        @(negedge clk);

        // Single-transaction vectors
        for (int i = 0; i < 6; i++) begin
            s0_valid = vt[i].v0; s0_addr = vt[i].a0; s0_wstrb = vt[i].ws0; s0_wdata = vt[i].wd0;
            s1_valid = vt[i].v1; s1_addr = vt[i].a1; s1_wstrb = vt[i].ws1; s1_wdata = vt[i].wd1;
            rd_val = vt[i].rd;
            @(negedge clk);
            chk($sformatf("v%0d_m_valid", i), {30'd0, rr_m_valid, fp_m_valid}, 32'd3);
            chk($sformatf("v%0d_grant_rr", i), {31'd0, rr_grant}, {31'd0, vt[i].g_rr});
            chk($sformatf("v%0d_grant_fp", i), {31'd0, fp_grant}, {31'd0, vt[i].g_fp});
            chk($sformatf("v%0d_addr_rr", i), {9'd0, rr_m_addr}, {9'd0, vt[i].g_rr ? vt[i].a1 : vt[i].a0});
            chk($sformatf("v%0d_wstrb_rr", i), {28'd0, rr_m_wstrb}, {28'd0, vt[i].g_rr ? vt[i].ws1 : vt[i].ws0});
            chk($sformatf("v%0d_wdata_rr", i), rr_m_wdata, vt[i].g_rr ? vt[i].wd1 : vt[i].wd0);
            chk($sformatf("v%0d_addr_fp", i), {9'd0, fp_m_addr}, {9'd0, vt[i].g_fp ? vt[i].a1 : vt[i].a0});
            chk($sformatf("v%0d_busy", i), {31'd0, rr_busy}, 32'd1);
            wait_ready();
            chk($sformatf("v%0d_win_ready", i), {31'd0, vt[i].g_rr ? rr_s1_ready : rr_s0_ready}, 32'd1);
            chk($sformatf("v%0d_lose_ready", i), {31'd0, vt[i].g_rr ? rr_s0_ready : rr_s1_ready}, 32'd0);
            chk($sformatf("v%0d_rdata", i), vt[i].g_rr ? rr_s1_rdata : rr_s0_rdata, vt[i].rd);
            chk($sformatf("v%0d_release_mv", i), {31'd0, rr_m_valid}, 32'd0);
            chk($sformatf("v%0d_fp_ready", i), {31'd0, vt[i].g_fp ? fp_s1_ready : fp_s0_ready}, 32'd1);
            s0_valid = 1'b0; s1_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_pulse_end", i), {29'd0, rr_s0_ready, rr_s1_ready, rr_busy}, 32'd0);
        end

        // Both ports requesting continuously for 8 round-robin transactions
        s0_valid = 1'b1; s1_valid = 1'b1;
        n = 0; r0 = 0; r1 = 0; f0 = 0; f1 = 0; done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (fp_s0_ready) f0++;
            if (fp_s1_ready) f1++;
            if (rr_s0_ready || rr_s1_ready) begin
                chk($sformatf("rr_seq%0d", n), {31'd0, rr_s1_ready}, n % 2);
                if (rr_s0_ready) r0++;
                if (rr_s1_ready) r1++;
                n++;
                if (n == 8) begin
                    done = 1'b1;
                    break;
                end
            end
        end
        chk("cont_timeout", {31'd0, done}, 32'd1);
        s0_valid = 1'b0; s1_valid = 1'b0;
        chk("rr_port0_count", r0, 4);
        chk("rr_port1_count", r1, 4);
        chk("fp_port0_count", f0, 8);
        chk("fp_port1_count", f1, 0);
        repeat (2) @(negedge clk);

`ifdef ARB_STATS_EN
        chk("rr_s0_grants", {16'd0, rr_s0_grants}, 32'd8);
        chk("rr_s1_grants", {16'd0, rr_s1_grants}, 32'd7);
        chk("fp_s0_grants_sat", {30'd0, fp_s0_grants}, 32'd3);
        chk("fp_s1_grants", {30'd0, fp_s1_grants}, 32'd2);
`else
        chk("stats_off", {rr_s0_grants, rr_s1_grants}, 32'd0);
        chk("stats_off_fp", {28'd0, fp_s0_grants, fp_s1_grants}, 32'd0);
`endif

        // Asynchronous reset during WAIT
        s0_valid = 1'b1; s0_addr = 23'h000040;
        @(negedge clk);
        chk("pre_rst_mv", {31'd0, rr_m_valid}, 32'd1);
        repeat (2) @(negedge clk);
        #2 sys_reset = 1'b1;
        #1;
        chk("async_rst_mv", {30'd0, rr_m_valid, fp_m_valid}, 32'd0);
        chk("async_rst_busy", {30'd0, rr_busy, fp_busy}, 32'd0);
        chk("async_rst_grants", {rr_s0_grants, rr_s1_grants}, 32'd0);
        chk("async_rst_grant", {31'd0, rr_grant}, 32'd1);
        s0_valid = 1'b0;
        @(negedge clk);
        sys_reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, rr_m_valid, rr_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
